// File: rtl/sigma_bus_arbiter.sv
// Two-master to one-slave arbiter for the sigma req/ack/resp bus.
// Routes read responses back to the issuing master and recovers from a missing response with a timeout.
module sigma_bus_arbiter #(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        fwd, sel, resp, to_hit;
  logic [31:0] resp_data;
  logic        mux_we;
  logic [31:0] mux_addr, mux_wdata;
  logic [3:0]  mux_be;
  logic        fwd_live, resp_live;

  always_comb begin
    mux_we    = sel ? m1_we_i    : m0_we_i;
    mux_addr  = sel ? m1_addr_i  : m0_addr_i;
    mux_be    = sel ? m1_be_i    : m0_be_i;
    mux_wdata = sel ? m1_wdata_i : m0_wdata_i;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    fwd       = 1'b0;
    sel       = owner_q;
    resp      = 1'b0;
    resp_data = '0;
    to_hit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          fwd = 1'b1;
          if (m0_req_i && m1_req_i) sel = ROUND_ROBIN ? rr_q : 1'b0;
          else                      sel = m1_req_i;
          owner_d = sel;
        end
      end
      HOLD: begin
        fwd = 1'b1;
        sel = owner_q;
      end
      WAIT: begin
        // A real response in the expiry cycle takes precedence over the synthetic one
        if (s_resp_i) begin
          resp      = 1'b1;
          resp_data = s_rdata_i;
          state_d   = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          resp      = 1'b1;
          resp_data = TIMEOUT_RDATA;
          to_hit    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fwd) begin
      if (s_ack_i) begin
        state_d = mux_we ? IDLE : WAIT;
        cnt_d   = '0;
        if (ROUND_ROBIN) rr_d = !sel;
      end else begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Forwarding is combinational, so outputs are masked while reset is held
  assign fwd_live  = fwd && !arst_i;
  assign resp_live = resp && !arst_i;

  assign s_req_o    = fwd_live;
  assign s_we_o     = fwd_live && mux_we;
  assign s_addr_o   = fwd_live ? mux_addr  : '0;
  assign s_be_o     = fwd_live ? mux_be    : '0;
  assign s_wdata_o  = fwd_live ? mux_wdata : '0;

  assign m0_ack_o   = fwd_live && s_ack_i && !sel;
  assign m1_ack_o   = fwd_live && s_ack_i && sel;
  assign m0_resp_o  = resp_live && !owner_q;
  assign m1_resp_o  = resp_live && owner_q;
  assign m0_rdata_o = m0_resp_o ? resp_data : '0;
  assign m1_rdata_o = m1_resp_o ? resp_data : '0;
  assign timeout_o  = resp_live && to_hit;

endmodule

// File: tb/tb_sigma_bus_arbiter.sv
// Scoreboard bench for sigma_bus_arbiter: stimulus queues expected acks/responses, a monitor pops and compares.
module tb_sigma_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        s_ack, s_resp;
  logic [31:0] s_rdata;

  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o, timeout_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_be_o;

  logic        f_m0_ack, f_m0_resp, f_m1_ack, f_m1_resp;
  logic [31:0] f_m0_rdata, f_m1_rdata;
  logic        f_s_req, f_s_we, f_timeout;
  logic [31:0] f_s_addr, f_s_wdata;
  logic [3:0]  f_s_be;

  always #5 clk = ~clk;

  sigma_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEADBEEF)) u_dut (
    .clk_i(clk), .arst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .timeout_o(timeout_o));

  sigma_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEADBEEF)) u_fix (
    .clk_i(clk), .arst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
    .m0_ack_o(f_m0_ack), .m0_resp_o(f_m0_resp), .m0_rdata_o(f_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
    .m1_ack_o(f_m1_ack), .m1_resp_o(f_m1_resp), .m1_rdata_o(f_m1_rdata),
    .s_req_o(f_s_req), .s_we_o(f_s_we), .s_addr_o(f_s_addr), .s_be_o(f_s_be), .s_wdata_o(f_s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_i(s_rdata), .timeout_o(f_timeout));

  typedef struct packed {logic mst; logic [31:0] addr;} ack_t;
  typedef struct packed {logic mst; logic [31:0] data; logic to;} rsp_t;

  ack_t ack_q[$];
  rsp_t rsp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   fix_ack0 = 0;
  int   fix_ack1 = 0;
  int   a0, a1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: DUT event with nothing expected (t=%0t)", name, $time);
  endtask

  task automatic exp_ack(input logic mst, input logic [31:0] addr);
    ack_q.push_back('{mst: mst, addr: addr});
  endtask

  task automatic exp_rsp(input logic mst, input logic [31:0] data, input logic to);
    rsp_q.push_back('{mst: mst, data: data, to: to});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    ack_t ea;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (f_m0_ack) fix_ack0++;
      if (f_m1_ack) fix_ack1++;
      if (m0_ack_o || m1_ack_o) begin
        if (ack_q.size() == 0) unexpected("ack_unexpected");
        else begin
          ea = ack_q.pop_front();
          check("ack_master", {31'd0, m1_ack_o}, {31'd0, ea.mst});
          check("ack_one_hot", {31'd0, m0_ack_o & m1_ack_o}, 32'd0);
          check("ack_addr", s_addr_o, ea.addr);
        end
      end
      if (m0_resp_o || m1_resp_o) begin
        if (rsp_q.size() == 0) unexpected("resp_unexpected");
        else begin
          er = rsp_q.pop_front();
          check("resp_master", {31'd0, m1_resp_o}, {31'd0, er.mst});
          check("resp_one_hot", {31'd0, m0_resp_o & m1_resp_o}, 32'd0);
          check("resp_rdata", m1_resp_o ? m1_rdata_o : m0_rdata_o, er.data);
          check("resp_timeout", {31'd0, timeout_o}, {31'd0, er.to});
        end
      end else if (timeout_o) begin
        unexpected("timeout_without_resp");
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h4; m0_be = 4'hF; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_be = 4'hF; m1_wdata = 32'h0;
    s_ack = 1'b1; s_resp = 1'b0; s_rdata = 32'h0;
    step(); step();
    @(negedge clk);
    check("rst_s_req", {31'd0, s_req_o}, 32'd0);
    check("rst_s_addr", s_addr_o, 32'd0);
    check("rst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    step();
    rst = 1'b0; m0_req = 1'b0; s_ack = 1'b0;

    // T1: m0 write acked immediately, then m1 write (rr_ptr back to m0)
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hA5A5A5A5; s_ack = 1'b1;
    exp_ack(1'b0, 32'h10);
    @(negedge clk);
    check("t1_s_we", {31'd0, s_we_o}, 32'd1);
    check("t1_s_wdata", s_wdata_o, 32'hA5A5A5A5);
    check("t1_s_be", {28'd0, s_be_o}, 32'hF);
    step();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    exp_ack(1'b1, 32'h20);
    step();
    m1_req = 1'b0; s_ack = 1'b0;

    // T2: contested reads, m0 served first, m1 waits through WAIT
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; s_ack = 1'b1;
    exp_ack(1'b0, 32'h100);
    step();
    m0_req = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    check("t2_wait_no_fwd", {31'd0, s_req_o}, 32'd0);
    step();
    s_resp = 1'b1; s_rdata = 32'h11;
    exp_rsp(1'b0, 32'h11, 1'b0);
    step();
    s_resp = 1'b0; s_ack = 1'b1;
    exp_ack(1'b1, 32'h200);
    step();
    m1_req = 1'b0; s_ack = 1'b0;
    step();
    s_resp = 1'b1; s_rdata = 32'h22;
    exp_rsp(1'b1, 32'h22, 1'b0);
    step();
    s_resp = 1'b0;

    // T3: continuous contested writes; RR alternates, fixed priority keeps m0
    a0 = fix_ack0; a1 = fix_ack1;
    for (int i = 0; i < 4; i++) begin
      step();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h300;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h400; s_ack = 1'b1;
      if (i % 2 == 0) exp_ack(1'b0, 32'h300);
      else            exp_ack(1'b1, 32'h400);
    end
    step();
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    check("t3_fixed_m0_acks", fix_ack0 - a0, 32'd4);
    check("t3_fixed_m1_acks", fix_ack1 - a1, 32'd0);

    // T4: slave stalls m1 for 5 cycles; m0 arrives but is not forwarded
    step();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h500;
    @(negedge clk);
    check("t4_hold_req", {31'd0, s_req_o}, 32'd1);
    check("t4_hold_addr", s_addr_o, 32'h500);
    for (int i = 0; i < 4; i++) begin
      step();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h600;
      @(negedge clk);
      check("t4_hold_addr_n", s_addr_o, 32'h500);
    end
    step();
    s_ack = 1'b1;
    exp_ack(1'b1, 32'h500);

    // T5: m0 read never answered; synthetic response 8 cycles after ack, late resp dropped
    step();
    m1_req = 1'b0;
    exp_ack(1'b0, 32'h600);
    step();
    m0_req = 1'b0; s_ack = 1'b0;
    repeat (6) step();
    step();
    exp_rsp(1'b0, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t5_timeout_pulse", {31'd0, timeout_o}, 32'd1);
    step();
    s_resp = 1'b1; s_rdata = 32'h33;
    @(negedge clk);
    check("t5_stray_m0", {31'd0, m0_resp_o}, 32'd0);
    check("t5_stray_m1", {31'd0, m1_resp_o}, 32'd0);
    step();
    s_resp = 1'b0;

    // T5b: real response arriving in the expiry cycle wins
    step();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h640; s_ack = 1'b1;
    exp_ack(1'b1, 32'h640);
    step();
    m1_req = 1'b0; s_ack = 1'b0;
    repeat (6) step();
    step();
    s_resp = 1'b1; s_rdata = 32'h44;
    exp_rsp(1'b1, 32'h44, 1'b0);
    @(negedge clk);
    check("t5b_no_timeout", {31'd0, timeout_o}, 32'd0);
    step();
    s_resp = 1'b0;

    // T6: reset during WAIT; afterwards m0 wins the first contested grant
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h700; s_ack = 1'b1;
    exp_ack(1'b0, 32'h700);
    step();
    m0_req = 1'b0; s_ack = 1'b0;
    step();
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h800;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h900;
    s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h55;
    @(negedge clk);
    check("t6_rst_s_req", {31'd0, s_req_o}, 32'd0);
    check("t6_rst_s_addr", s_addr_o, 32'd0);
    check("t6_rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    check("t6_rst_resps", {30'd0, m1_resp_o, m0_resp_o}, 32'd0);
    check("t6_rst_rdata", m0_rdata_o, 32'd0);
    step();
    rst = 1'b0; s_resp = 1'b0;
    exp_ack(1'b0, 32'h800);
    @(negedge clk);
    check("t6_first_we", {31'd0, s_we_o}, 32'd1);
    step();
    m0_req = 1'b0;
    exp_ack(1'b1, 32'h900);
    step();
    m1_req = 1'b0; s_ack = 1'b0;
    step(); step();
    @(negedge clk);
    check("ack_queue_drained", ack_q.size(), 32'd0);
    check("resp_queue_drained", rsp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
